seg7_scan4: RTL and testbench
=============================

// Module: seg7_scan4
// PURPOSE
//  Reads four BCD digit buses (0-9) from the clock's counters and drives the
//  board's time-multiplexed 4-digit common-anode 7-segment display.
//  Sits between the counter chain and the top-level pins.
//  Contains a scan prescaler, a digit-select counter and a registered output
//  stage with segment decoding.
// PARAMETERS
//  SCAN_DIV  50000  CP cycles per digit slot (50 MHz -> 1 kHz per digit); must be >= 2
// PORTS
//  CP      in   1  clock, rising edge
//  nCR     in   1  asynchronous active-low reset
//  EN      in   1  scan enable; low = freeze scan and blank display
//  D0      in   4  BCD digit, rightmost position (AN[0])
//  D1      in   4  BCD digit, position AN[1]
//  D2      in   4  BCD digit, position AN[2]
//  D3      in   4  BCD digit, leftmost position (AN[3])
//  DP_IN   in   4  decimal-point request per digit, active-high, bit i -> digit i
//  AN      out  4  digit anodes, active-low, one-hot-low when lit
//  SEG     out  7  segments {a,b,c,d,e,f,g}, active-low
//  DP      out  1  decimal point, active-low
// BEHAVIOUR
//  - One clock: CP. Reset is nCR, asynchronous, active-low.
//  - Reset values: prescaler=0, sel=0, AN=4'b1111, SEG=7'b1111111, DP=1.
//  - Prescaler counts 0..SCAN_DIV-1 while EN=1. tick=1 when prescaler==SCAN_DIV-1.
//    On tick, the prescaler wraps to 0.
//  - sel (2 bits) increments on tick and wraps 3->0. Each digit is lit for exactly
//    SCAN_DIV cycles, and a full frame is 4*SCAN_DIV cycles.
//  - Output stage is registered on every CP edge:
//    AN  <= ~(4'b0001 << sel)
//    SEG <= dec(D[sel])
//    DP  <= ~DP_IN[sel]
//  - Latency: a change on D*/DP_IN or sel is visible on the pins 1 CP later.
//    There is no input synchronisation; inputs are synchronous to CP.
//  - dec() lookup:
//    0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//    5=0100100  6=0100000  7=0001111  8=0000000  9=0000100
//    Non-BCD codes 1010-1111 show a dash: 1111110 (only g lit).
//  - EN=0: prescaler and sel hold their values. Next edge: AN=1111, SEG=1111111,
//    DP=1. When EN returns to 1, scanning resumes from the held prescaler/sel
//    values with no skipped slot.
//  - Reset mid-frame: all state and outputs go immediately to reset values.
//    After release, the first lit digit is D0, on the first CP edge.
//  - AN never has more than one bit low at any time, including at sel wrap
//    and at EN transitions.
// CONFIGURATION
//  Macro LEADING_ZERO_BLANK_EN.
//  - Defined: the slot for digit i (i=3,2,1) is blanked when all digits i..3 are 0.
//    Blanked means AN stays 4'b1111, SEG=1111111 and DP=1 for that slot, unless
//    DP_IN[i]=1, in which case that digit is shown normally.
//    D0 is never blanked. Slot timing is unchanged; blanked slots still last
//    SCAN_DIV cycles.
//  - Undefined: all four digits are always displayed, including leading zeros.
// TESTING  (run with SCAN_DIV=4)
//  - Reset: nCR=0 for 3 CP -> AN=1111, SEG=1111111, DP=1.
//    Release -> next edge AN=1110.
//  - Scan: D3..D0=1,2,3,4, EN=1 -> AN sequence 1110,1101,1011,0111, each held
//    4 CP. SEG 1001100, 0000110, 0010010, 1001111. Wrap back to 1110.
//  - Decode sweep: D0 = 0..15 while sel=0 -> SEG matches the table.
//    Codes 10-15 -> 1111110. 1-cycle latency is checked.
//  - Freeze: EN=0 mid-slot 2 -> next edge AN=1111. Hold 10 CP, EN=1 ->
//    AN=1011 for the remaining cycles of slot 2.
//  - DP: DP_IN=0100 -> DP=0 only while AN=1011.
//    Async reset pulse mid-slot 3 -> outputs go to reset values without waiting
//    for a CP edge.
//  - LEADING_ZERO_BLANK_EN defined: D3..D0=0,0,0,7 -> only the AN=1110 slot lit
//    (SEG=0001111). Other slots AN=1111. With DP_IN=0010, slot 1 shows 0000001.

Source files
------------

// File: rtl/seg7_scan4_if.sv
// Display-side bundle for seg7_scan4: BCD digits, DP requests and scan enable in;
// active-low anode/segment/decimal-point pins out.
interface seg7_scan4_if;
  logic       EN;
  logic [3:0] D0;
  logic [3:0] D1;
  logic [3:0] D2;
  logic [3:0] D3;
  logic [3:0] DP_IN;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  modport master (output EN, D0, D1, D2, D3, DP_IN, input AN, SEG, DP);
  modport slave  (input EN, D0, D1, D2, D3, DP_IN, output AN, SEG, DP);
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed common-anode 7-segment driver with registered pins.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (D0 always shown).

module seg7_scan4_lane #(
  parameter bit BLANKABLE = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       dp_req,
  input  logic       upper_zero,
  output logic [6:0] seg,
  output logic       blank
);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  always_comb begin
    seg = 7'b1111110;
    unique case (digit)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111110;
    endcase
  end

  // A requested decimal point keeps an otherwise-leading zero visible.
  assign blank = LZB && BLANKABLE && upper_zero && (digit == 4'd0) && !dp_req;
endmodule

module seg7_scan4 #(
  parameter int SCAN_DIV = 50000
) (
  input  logic          CP,
  input  logic          nCR,
  seg7_scan4_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg7_scan4: SCAN_DIV must be >= 2");
  end

  logic [PW-1:0]                  pre;
  logic [1:0]                     sel;
  logic                           tick;
  logic [NUM_LANES-1:0][3:0]      dig;
  logic [NUM_LANES-1:0][6:0]      lane_seg;
  logic [NUM_LANES-1:0]           lane_blank;
  logic [NUM_LANES-1:0]           upper_zero;
  logic                           lit;

  assign dig  = {bus.D3, bus.D2, bus.D1, bus.D0};
  assign tick = (pre == PW'(SCAN_DIV - 1));

  // upper_zero[i]: every digit above position i is zero.
  always_comb begin
    upper_zero = '1;
    for (int i = NUM_LANES - 2; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (dig[i+1] == 4'd0);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    seg7_scan4_lane #(.BLANKABLE(g != 0)) u_lane (
      .digit      (dig[g]),
      .dp_req     (bus.DP_IN[g]),
      .upper_zero (upper_zero[g]),
      .seg        (lane_seg[g]),
      .blank      (lane_blank[g])
    );
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      pre <= '0;
      sel <= '0;
    end else if (bus.EN) begin
      if (tick) begin
        pre <= '0;
        sel <= sel + 2'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  assign lit = bus.EN && !lane_blank[sel];

  // Outputs come straight from flops so the anodes never glitch two-low.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      bus.AN  <= 4'b1111;
      bus.SEG <= 7'b1111111;
      bus.DP  <= 1'b1;
    end else if (lit) begin
      bus.AN  <= ~(4'b0001 << sel);
      bus.SEG <= lane_seg[sel];
      bus.DP  <= ~bus.DP_IN[sel];
    end else begin
      bus.AN  <= 4'b1111;
      bus.SEG <= 7'b1111111;
      bus.DP  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 (SCAN_DIV=4) with a slot-count reference model
// checked every cycle plus hand-computed literal expectations.
module tb_seg7_scan4;
  localparam int SCAN_DIV = 4;

  logic CP  = 1'b0;
  logic nCR = 1'b0;
  seg7_scan4_if bus();

  seg7_scan4 #(.SCAN_DIV(SCAN_DIV)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus.slave)
  );

  always #5 CP = ~CP;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the slot is the number of enabled cycles since reset,
  // divided into SCAN_DIV-long slots, modulo four digits.
  logic [3:0] e_an  = 4'b1111;
  logic [6:0] e_seg = 7'b1111111;
  logic       e_dp  = 1'b1;
  int         en_cnt = 0;

  function automatic logic [3:0] digit_at(input int j);
    case (j)
      0: return bus.D0;
      1: return bus.D1;
      2: return bus.D2;
      default: return bus.D3;
    endcase
  endfunction

  function automatic bit blanked(input int s);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b0;
    for (int j = s; j < 4; j++)
      if (digit_at(j) != 4'd0) return 1'b0;
    return !bus.DP_IN[s];
`else
    return (s < 0);
`endif
  endfunction

  always @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; en_cnt = 0;
    end else if (!bus.EN) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      int s;
      s = (en_cnt / SCAN_DIV) % 4;
      if (blanked(s)) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_an  = an_tab[s];
        e_seg = seg_tab[digit_at(s)];
        e_dp  = !bus.DP_IN[s];
      end
      en_cnt++;
    end
  end

  always @(negedge CP) begin
    chk("model_an",  32'(bus.AN),  32'(e_an));
    chk("model_seg", 32'(bus.SEG), 32'(e_seg));
    chk("model_dp",  32'(bus.DP),  32'(e_dp));
    chk("an_onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
  end

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    step();
    nCR = 1'b1;
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    bus.D3 = d3; bus.D2 = d2; bus.D1 = d1; bus.D0 = d0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.EN = 1'b1; bus.DP_IN = 4'b0000;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);

    // Reset held for three edges
    repeat (3) step();
    chk("rst_an",  32'(bus.AN),  32'hF);
    chk("rst_seg", 32'(bus.SEG), 32'h7F);
    chk("rst_dp",  32'(bus.DP),  32'h1);
    nCR = 1'b1;

    // Scan 1,2,3,4: each anode held SCAN_DIV edges, then wrap
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < SCAN_DIV; k++) begin
        step();
        chk("scan_an",  32'(bus.AN),  32'(an_tab[s]));
        chk("scan_seg", 32'(bus.SEG), 32'(seg_tab[4 - s]));
      end
    step();
    chk("wrap_an", 32'(bus.AN), 32'b1110);
    chk("wrap_seg", 32'(bus.SEG), 32'b1001100);

    // Decode sweep in slot 0 with one-edge latency
    for (int c = 0; c < 16; c++) begin
      logic [3:0] nx;
      nCR = 1'b0;
      step();
      bus.D0 = 4'(c);
      nCR = 1'b1;
      step();
      chk("dec_an", 32'(bus.AN), 32'b1110);
      chk("dec_seg", 32'(bus.SEG), 32'(seg_tab[c]));
      nx = 4'(c + 1);
      bus.D0 = nx;
      chk("dec_hold", 32'(bus.SEG), 32'(seg_tab[c]));
      step();
      chk("dec_next", 32'(bus.SEG), 32'(seg_tab[nx]));
    end
    chk("dec_dash_lit", 32'(seg_tab[12]), 32'b1111110);

    // Freeze mid-slot 2 for ten edges, then finish the slot
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    do_reset();
    repeat (10) step();
    chk("frz_pre", 32'(bus.AN), 32'b1011);
    bus.EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frz_an", 32'(bus.AN), 32'hF);
      chk("frz_seg", 32'(bus.SEG), 32'h7F);
    end
    bus.EN = 1'b1;
    step(); chk("frz_res0", 32'(bus.AN), 32'b1011);
    step(); chk("frz_res1", 32'(bus.AN), 32'b1011);
    step(); chk("frz_next", 32'(bus.AN), 32'b0111);

    // Decimal point on digit 2 only
    bus.DP_IN = 4'b0100;
    do_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < SCAN_DIV; k++) begin
        step();
        chk("dp_val", 32'(bus.DP), (s == 2) ? 32'd0 : 32'd1);
      end

    // Async reset pulse mid-slot 3, between edges
    repeat (14) step();
    chk("ar_pre", 32'(bus.AN), 32'b0111);
    #3 nCR = 1'b0;
    #1;
    chk("ar_an",  32'(bus.AN),  32'hF);
    chk("ar_seg", 32'(bus.SEG), 32'h7F);
    chk("ar_dp",  32'(bus.DP),  32'h1);
    step();
    nCR = 1'b1;
    step();
    chk("ar_first", 32'(bus.AN), 32'b1110);

    // Leading zeros: 0,0,0,7 then with DP on digit 1
    bus.DP_IN = 4'b0000;
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++)
        for (int k = 0; k < SCAN_DIV; k++) begin
          logic [3:0] ea;
          logic [6:0] es;
          step();
          ea = an_tab[s];
          es = (s == 0) ? 7'b0001111 : 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
          if (s > 1 || (s == 1 && p == 0)) begin
            ea = 4'b1111;
            es = 7'b1111111;
          end
`endif
          chk("lz_an",  32'(bus.AN),  32'(ea));
          chk("lz_seg", 32'(bus.SEG), 32'(es));
          chk("lz_dp",  32'(bus.DP),  (p == 1 && s == 1) ? 32'd0 : 32'd1);
        end
      bus.DP_IN = 4'b0010;
    end

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
